dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data memory port: mina core (CPU) and debug/loader (DBG).
// Grants are combinational; read-return valid is registered and steered to the read's issuer.
module dmem_arbiter #(
    parameter int unsigned CPU_PRIORITY  = 1,
    parameter int unsigned MAX_CPU_BURST = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wrdata,
    input  logic [3:0]  cpu_wrstb,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rddata,
    output logic        cpu_rvalid,

    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wrdata,
    input  logic [3:0]  dbg_wrstb,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rddata,
    output logic        dbg_rvalid,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    output logic [3:0]  mem_wrstb,
    input  logic [31:0] mem_rddata
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_CPU_BURST);

    owner_t      last_gnt;
    logic [7:0]  streak;
    logic [7:0]  streak_nxt;
    logic        pend_valid;
    owner_t      pend_owner;

    logic        cpu_win;
    logic        dbg_win;
    logic        any_win;
    logic        rd_grant;

    // Grants are gated by rst_n so nothing reaches dmem while reset is held.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (rst_n) begin
            if (cpu_req && dbg_req) begin
                if (CPU_PRIORITY != 0) begin
                    if (streak == BURST_LIMIT) dbg_win = 1'b1;
                    else                       cpu_win = 1'b1;
                end else begin
                    if (last_gnt == OWN_CPU) dbg_win = 1'b1;
                    else                     cpu_win = 1'b1;
                end
            end else begin
                cpu_win = cpu_req;
                dbg_win = dbg_req;
            end
        end
    end

    assign cpu_gnt = cpu_win;
    assign dbg_gnt = dbg_win;
    assign any_win = cpu_win | dbg_win;

    always_comb begin
        mem_addr   = '0;
        mem_wrdata = '0;
        mem_wrstb  = '0;
        if (cpu_win) begin
            mem_addr   = cpu_addr;
            mem_wrdata = cpu_wrdata;
            mem_wrstb  = cpu_wrstb;
        end else if (dbg_win) begin
            mem_addr   = dbg_addr;
            mem_wrdata = dbg_wrdata;
            mem_wrstb  = dbg_wrstb;
        end
    end

    assign rd_grant = any_win && (mem_wrstb == 4'h0);

    // Streak counts only contested CPU wins; any cycle without dbg_req resets it.
    always_comb begin
        streak_nxt = '0;
        if (cpu_win && dbg_req) begin
            if (streak >= BURST_LIMIT) streak_nxt = BURST_LIMIT;
            else                       streak_nxt = streak + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= OWN_DBG;
            streak     <= '0;
            pend_valid <= 1'b0;
            pend_owner <= OWN_CPU;
        end else begin
            if (cpu_win)      last_gnt <= OWN_CPU;
            else if (dbg_win) last_gnt <= OWN_DBG;
            streak     <= streak_nxt;
            pend_valid <= rd_grant;
            pend_owner <= dbg_win ? OWN_DBG : OWN_CPU;
        end
    end

    assign cpu_rvalid = pend_valid && (pend_owner == OWN_CPU);
    assign dbg_rvalid = pend_valid && (pend_owner == OWN_DBG);
    assign cpu_rddata = mem_rddata;
    assign dbg_rddata = mem_rddata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four parameterisations share one stimulus stream and are
// checked every cycle against a rule-level reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cpu_req, dbg_req;
    logic [31:0] cpu_addr, cpu_wrdata, dbg_addr, dbg_wrdata, mem_rddata;
    logic [3:0]  cpu_wrstb, dbg_wrstb;

    logic [3:0]  cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
    logic [31:0] cpu_rddata [4];
    logic [31:0] dbg_rddata [4];
    logic [31:0] mem_addr   [4];
    logic [31:0] mem_wrdata [4];
    logic [3:0]  mem_wrstb  [4];

    // u0: priority/8, u1: round-robin, u2: priority/2, u3: priority/1
    dmem_arbiter #(.CPU_PRIORITY(1), .MAX_CPU_BURST(8)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wrstb(cpu_wrstb),
        .cpu_gnt(cpu_gnt[0]), .cpu_rddata(cpu_rddata[0]), .cpu_rvalid(cpu_rvalid[0]),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wrdata(dbg_wrdata), .dbg_wrstb(dbg_wrstb),
        .dbg_gnt(dbg_gnt[0]), .dbg_rddata(dbg_rddata[0]), .dbg_rvalid(dbg_rvalid[0]),
        .mem_addr(mem_addr[0]), .mem_wrdata(mem_wrdata[0]), .mem_wrstb(mem_wrstb[0]),
        .mem_rddata(mem_rddata));
    dmem_arbiter #(.CPU_PRIORITY(0), .MAX_CPU_BURST(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wrstb(cpu_wrstb),
        .cpu_gnt(cpu_gnt[1]), .cpu_rddata(cpu_rddata[1]), .cpu_rvalid(cpu_rvalid[1]),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wrdata(dbg_wrdata), .dbg_wrstb(dbg_wrstb),
        .dbg_gnt(dbg_gnt[1]), .dbg_rddata(dbg_rddata[1]), .dbg_rvalid(dbg_rvalid[1]),
        .mem_addr(mem_addr[1]), .mem_wrdata(mem_wrdata[1]), .mem_wrstb(mem_wrstb[1]),
        .mem_rddata(mem_rddata));
    dmem_arbiter #(.CPU_PRIORITY(1), .MAX_CPU_BURST(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wrstb(cpu_wrstb),
        .cpu_gnt(cpu_gnt[2]), .cpu_rddata(cpu_rddata[2]), .cpu_rvalid(cpu_rvalid[2]),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wrdata(dbg_wrdata), .dbg_wrstb(dbg_wrstb),
        .dbg_gnt(dbg_gnt[2]), .dbg_rddata(dbg_rddata[2]), .dbg_rvalid(dbg_rvalid[2]),
        .mem_addr(mem_addr[2]), .mem_wrdata(mem_wrdata[2]), .mem_wrstb(mem_wrstb[2]),
        .mem_rddata(mem_rddata));
    dmem_arbiter #(.CPU_PRIORITY(1), .MAX_CPU_BURST(1)) u3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wrstb(cpu_wrstb),
        .cpu_gnt(cpu_gnt[3]), .cpu_rddata(cpu_rddata[3]), .cpu_rvalid(cpu_rvalid[3]),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wrdata(dbg_wrdata), .dbg_wrstb(dbg_wrstb),
        .dbg_gnt(dbg_gnt[3]), .dbg_rddata(dbg_rddata[3]), .dbg_rvalid(dbg_rvalid[3]),
        .mem_addr(mem_addr[3]), .mem_wrdata(mem_wrdata[3]), .mem_wrstb(mem_wrstb[3]),
        .mem_rddata(mem_rddata));

    // Reference model: winner codes 0 = none, 1 = CPU, 2 = DBG
    int m_prio [4] = '{1, 0, 1, 1};
    int m_max  [4] = '{8, 8, 2, 1};
    int m_streak [4];
    int m_last   [4];
    bit m_pv     [4];
    int m_po     [4];
    int last_win [4];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s[u%0d]: observed %h expected %h", tag, idx, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_streak[i] = 0;
            m_last[i]   = 2;
            m_pv[i]     = 1'b0;
            m_po[i]     = 1;
        end
    endtask

    task automatic check_all();
        if (!rst_n) model_reset();
        for (int i = 0; i < 4; i++) begin
            int win;
            logic [31:0] ea, ed;
            logic [3:0]  es;
            win = 0;
            if (rst_n) begin
                if (cpu_req && dbg_req) begin
                    if (m_prio[i] == 1) win = (m_streak[i] >= m_max[i]) ? 2 : 1;
                    else                win = (m_last[i] == 1) ? 2 : 1;
                end else if (cpu_req) win = 1;
                else if (dbg_req)     win = 2;
            end
            ea = (win == 1) ? cpu_addr   : (win == 2) ? dbg_addr   : 32'h0;
            ed = (win == 1) ? cpu_wrdata : (win == 2) ? dbg_wrdata : 32'h0;
            es = (win == 1) ? cpu_wrstb  : (win == 2) ? dbg_wrstb  : 4'h0;
            last_win[i] = win;

            chk("cpu_gnt",    i, 32'(cpu_gnt[i]),    32'(win == 1));
            chk("dbg_gnt",    i, 32'(dbg_gnt[i]),    32'(win == 2));
            chk("mem_addr",   i, mem_addr[i],        ea);
            chk("mem_wrdata", i, mem_wrdata[i],      ed);
            chk("mem_wrstb",  i, 32'(mem_wrstb[i]),  32'(es));
            chk("cpu_rvalid", i, 32'(cpu_rvalid[i]), 32'(m_pv[i] && m_po[i] == 1));
            chk("dbg_rvalid", i, 32'(dbg_rvalid[i]), 32'(m_pv[i] && m_po[i] == 2));
            chk("cpu_rddata", i, cpu_rddata[i],      mem_rddata);
            chk("dbg_rddata", i, dbg_rddata[i],      mem_rddata);

            // State the next clock edge should leave behind
            if (rst_n) begin
                if (win != 0) m_last[i] = win;
                if (win == 1 && dbg_req)
                    m_streak[i] = (m_streak[i] + 1 > m_max[i]) ? m_max[i] : m_streak[i] + 1;
                else
                    m_streak[i] = 0;
                m_pv[i] = (win != 0) && (es == 4'h0);
                m_po[i] = win;
            end
        end
    endtask

    task automatic step(input logic r, input logic cr, input logic dr,
                        input logic [31:0] ca, input logic [31:0] cw, input logic [3:0] cs,
                        input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
        @(negedge clk);
        rst_n      = r;
        cpu_req    = cr;
        dbg_req    = dr;
        cpu_addr   = ca;
        cpu_wrdata = cw;
        cpu_wrstb  = cs;
        dbg_addr   = da;
        dbg_wrdata = dw;
        dbg_wrstb  = ds;
        mem_rddata = $urandom;
        #1;
        check_all();
    endtask

    task automatic step_rd(input logic r, input logic cr, input logic dr);
        step(r, cr, dr, $urandom, $urandom, 4'h0, $urandom, $urandom, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; dbg_req = 1'b0;
        cpu_addr = '0; cpu_wrdata = '0; cpu_wrstb = '0;
        dbg_addr = '0; dbg_wrdata = '0; dbg_wrstb = '0;
        mem_rddata = '0;
        model_reset();

        // Reset held with both requesting: everything quiet
        for (int k = 0; k < 3; k++) step_rd(1'b0, 1'b1, 1'b1);
        step_rd(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) chk("first_cpu_gnt", i, 32'(cpu_gnt[i]), 32'd1);

        // CPU-only read then full-word write
        step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0);
        chk("rd_then_rvalid", 0, 32'(cpu_rvalid[0]), 32'd1);
        chk("wr_strobe", 0, 32'(mem_wrstb[0]), 32'hF);
        step_rd(1'b1, 1'b0, 1'b0);
        chk("wr_no_rvalid", 0, 32'(cpu_rvalid[0]), 32'd0);

        // Full contention for 20 cycles from a fresh reset
        step_rd(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step_rd(1'b1, 1'b1, 1'b1);
            chk("burst_pattern", 0, 32'(cpu_gnt[0]), 32'(!(k == 8 || k == 17)));
            chk("rr_pattern",    1, 32'(cpu_gnt[1]), 32'(k % 2 == 0));
            chk("alt_pattern",   3, 32'(cpu_gnt[3]), 32'(k % 2 == 0));
        end
        step_rd(1'b1, 1'b0, 1'b0);

        // DBG read in flight when reset drops: its rvalid is lost
        step_rd(1'b1, 1'b0, 1'b1);
        step_rd(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk("rvalid_dropped", i, 32'(dbg_rvalid[i]), 32'd0);
        step_rd(1'b0, 1'b0, 1'b0);
        step_rd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk("no_late_rvalid", i, 32'(dbg_rvalid[i]), 32'd0);
        step_rd(1'b1, 1'b1, 1'b1);
        chk("streak_cleared", 3, 32'(cpu_gnt[3]), 32'd1);

        // Sparse dbg_req pulses never build a streak
        step_rd(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step_rd(1'b1, 1'b1, (k % 3) == 2);
            chk("pulse_cpu_wins", 2, 32'(cpu_gnt[2]), 32'd1);
        end

        // Randomised traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            logic r, cr, dr;
            logic [3:0] cs, ds;
            r  = ($urandom_range(0, 49) != 0);
            cr = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 2) != 0);
            cs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            ds = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(r, cr, dr, $urandom, $urandom, cs, $urandom, $urandom, ds);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
